// File: rtl/sseg_scan_driver.sv
// Scan driver for a 4-digit common-anode seven-segment display.
// New value/dp/blank data is committed only at the frame wrap, so a scan never tears.
//
// state | meaning
// SHOW  | current digit anode driven, cathodes show the decoded nibble
// GAP   | all anodes off between digits to prevent ghosting
module sseg_scan_driver #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int GAP_CYCLES     = 2,
  parameter int LZ_SUPPRESS    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [7:0]  SSEG_CA,
  output logic [3:0]  SSEG_AN,
  output logic        frame_tick
);

  localparam int CNT_MAX = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic {ST_SHOW = 1'b0, ST_GAP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [15:0]      pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [3:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [3:0]       pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       ca_q, ca_d;
  logic [3:0]       nib;
  logic [3:0]       nz;
  logic             lz_dark;
  logic             dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tick_d  = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else begin
            idx_d  = idx_q + 2'd1;
            tick_d = (idx_q == 2'd3);
          end
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          idx_d   = idx_q + 2'd1;
          tick_d  = (idx_q == 2'd3);
        end
      end
    endcase
  end

  // tick_q marks the first cycle of a new frame; a load in that same cycle bypasses pending.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
    end
    if (tick_q) begin
      act_val_d   = pend_val_d;
      act_dp_d    = pend_dp_d;
      act_blank_d = pend_blank_d;
    end
  end

  always_comb begin
    nib     = act_val_d[{idx_q, 2'b00} +: 4];
    nz      = {|act_val_d[15:12], |act_val_d[11:8], |act_val_d[7:4], |act_val_d[3:0]};
    lz_dark = (LZ_SUPPRESS != 0) && (idx_q != 2'd0) && ((nz >> idx_q) == 4'd0);
    dark    = (state_q == ST_GAP) || act_blank_d[idx_q] || lz_dark;
    an_d    = (state_q == ST_SHOW) ? ~(4'b0001 << idx_q) : 4'hF;
    ca_d    = dark ? 8'hFF : {~act_dp_d[idx_q], hex7(nib)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SHOW;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      an_q         <= 4'hF;
      ca_q         <= 8'hFF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      ca_q         <= ca_d;
    end
  end

  assign SSEG_AN    = an_q;
  assign SSEG_CA    = ca_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: three parameter sets share one stimulus stream and are
// compared every cycle against a timeline model derived from elapsed cycles and load history.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;

  logic [7:0] ca_a, ca_b, ca_c;
  logic [3:0] an_a, an_b, an_c;
  logic       tk_a, tk_b, tk_c;

  sseg_scan_driver #(.REFRESH_CYCLES(4), .GAP_CYCLES(1), .LZ_SUPPRESS(0)) dut_a (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
    .SSEG_CA(ca_a), .SSEG_AN(an_a), .frame_tick(tk_a));
  sseg_scan_driver #(.REFRESH_CYCLES(4), .GAP_CYCLES(1), .LZ_SUPPRESS(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
    .SSEG_CA(ca_b), .SSEG_AN(an_b), .frame_tick(tk_b));
  sseg_scan_driver #(.REFRESH_CYCLES(4), .GAP_CYCLES(0), .LZ_SUPPRESS(0)) dut_c (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
    .SSEG_CA(ca_c), .SSEG_AN(an_c), .frame_tick(tk_c));

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  b;
  } ld_t;

  ld_t lq[$];
  int  s = 0;
  int  passed = 0;
  int  total = 0;
  bit  armed = 1'b0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Pins in cycle cyc reflect the scan position of cycle cyc-1; frame f shows the latest load
  // made no later than the frame's first cycle (4*period*f).
  function automatic void model(input int r, input int g, input int lz, input int cyc,
                                output logic [3:0] an, output logic [7:0] ca, output logic tk);
    int p, st, pos, dig, f;
    logic [15:0] v;
    logic [3:0]  d, b, nib;
    bit dark;
    p  = r + g;
    an = 4'hF;
    ca = 8'hFF;
    tk = (cyc > 0) && (cyc % (4 * p) == 0);
    if (cyc == 0) return;
    st  = cyc - 1;
    pos = st % (4 * p);
    dig = pos / p;
    if (pos % p >= r) return;
    an = ~(4'b0001 << dig);
    f  = st / (4 * p);
    v  = '0;
    d  = '0;
    b  = '0;
    if (f > 0) begin
      foreach (lq[i]) begin
        if (lq[i].c <= 4 * p * f) begin
          v = lq[i].v;
          d = lq[i].d;
          b = lq[i].b;
        end
      end
    end
    nib  = v[dig*4 +: 4];
    dark = b[dig] || (lz != 0 && dig > 0 && (v >> (4 * dig)) == 16'd0);
    if (!dark) ca = {~d[dig], seg_tab[nib]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h at cycle %0d", tag, obs, exp, s);
  endtask

  task automatic check_all();
    logic [3:0] ea;
    logic [7:0] ec;
    logic       et;
    model(4, 1, 0, s, ea, ec, et);
    chk("an_gap1", {4'h0, an_a}, {4'h0, ea});
    chk("ca_gap1", ca_a, ec);
    chk("tick_gap1", {7'h0, tk_a}, {7'h0, et});
    model(4, 1, 1, s, ea, ec, et);
    chk("an_lz", {4'h0, an_b}, {4'h0, ea});
    chk("ca_lz", ca_b, ec);
    chk("tick_lz", {7'h0, tk_b}, {7'h0, et});
    model(4, 0, 0, s, ea, ec, et);
    chk("an_gap0", {4'h0, an_c}, {4'h0, ea});
    chk("ca_gap0", ca_c, ec);
    chk("tick_gap0", {7'h0, tk_c}, {7'h0, et});
  endtask

  task automatic cycle(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] b);
    reset = r;
    load  = ld;
    value = v;
    dp    = d;
    blank = b;
    @(negedge clk);
    if (armed) check_all();
    @(posedge clk);
    if (r) begin
      s = 0;
      lq.delete();
      armed = 1'b1;
    end else begin
      if (ld) lq.push_back('{s, v, d, b});
      s++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    cycle(1'b0, 1'b1, v, d, b);
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    int k;
    #1;
    do_reset(3);
    idle(45);

    while (s % 20 != 7) idle(1);
    do_load(16'h12AF, 4'b0100, 4'b0000);
    idle(50);

    while (s % 20 != 3) idle(1);
    do_load(16'h1111, 4'b0000, 4'b0000);
    idle(5);
    do_load(16'h2222, 4'b0000, 4'b0000);
    idle(45);

    while (s % 20 != 0) idle(1);
    do_load(16'h3C4D, 4'b1001, 4'b0000);
    idle(25);

    do_load(16'h0005, 4'b0000, 4'b0000);
    idle(45);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(45);
    do_load(16'h0500, 4'b1111, 4'b0000);
    idle(45);
    do_load(16'h8888, 4'b0000, 4'b1000);
    idle(45);

    while (s % 20 != 11) idle(1);
    do_reset(1);
    idle(25);

    repeat (60) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (k < 7) begin
        do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                (k < 4) ? 4'h0 : 4'($urandom));
      end
      idle(int'($urandom_range(0, 30)));
    end
    idle(45);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit, common-anode seven-segment display on the board top level.
- Consumes a 16-bit hex value plus per-digit decimal-point and blank masks from the test logic.
- Drives the active-low SSEG_CA / SSEG_AN pins directly.
- Latches new data on a load strobe and commits it only at a frame boundary, so the displayed digits never tear mid-scan.

Parameters:
- REFRESH_CYCLES, 100000: clocks each digit is lit (1 ms at 100 MHz); must be >= 2.
- GAP_CYCLES, 2: clocks with all anodes off between digits (anti-ghosting); 0 allowed.
- LZ_SUPPRESS, 0: 1 = blank leading zero digits 3..1; digit 0 is never suppressed.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures value/dp/blank into the pending registers.
- value  in  16  hex digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp  in  4  decimal point per digit, 1 = lit.
- blank  in  4  per-digit force-blank, 1 = dark.
- SSEG_CA  out  8  active-low cathodes; [0..6] = segments a..g, [7] = dp.
- SSEG_AN  out  4  active-low anodes; [0] = digit 0.
- frame_tick  out  1  one-cycle pulse when pending data is committed (start of digit 0).

Behaviour:
- Reset (sampled on the clk edge):
  - SSEG_AN=4'hF, SSEG_CA=8'hFF, frame_tick=0.
  - State=SHOW, digit index=0, cycle counter=0.
  - Pending and active value/dp/blank = 0.
- Reset mid-frame aborts the scan immediately with the same values; pending data is lost.
- State machine:
  - SHOW: counter counts 0..REFRESH_CYCLES-1. At terminal count: counter clears; go to GAP if GAP_CYCLES>0, else advance index and stay in SHOW.
  - GAP: counter counts 0..GAP_CYCLES-1. At terminal count: counter clears, index advances, return to SHOW.
- Index advance: 0→1→2→3→0. The 3→0 wrap is the frame boundary.
- Frame boundary:
  - Active registers <= pending registers.
  - frame_tick=1 for exactly that one cycle.
- First SHOW after reset counts as digit 0 with active data all zero; no frame_tick until the first 3→0 wrap.
- Load:
  - load=1 overwrites all pending registers; back-to-back loads: last wins.
  - A load in the same cycle as a frame boundary bypasses pending: the new data commits at that boundary.
  - A load at any other time is displayed starting at the next frame.
- Outputs are registered from current state and active data, so there is one clock of latency from a state/index change to the pins.
- Period: one digit = REFRESH_CYCLES+GAP_CYCLES clocks; one frame = 4× that.
- SSEG_AN:
  - In SHOW: ~(4'b0001 << index).
  - In GAP: 4'hF.
- SSEG_CA in SHOW, digit not dark:
  - [6:0] = active-low hex decode of the nibble.
  - Decode codes (CA[6:0], g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - [7] = ~dp[index].
- SSEG_CA dark cases: 8'hFF, including dp, when any of these holds:
  - state is GAP;
  - blank[index]=1;
  - LZ_SUPPRESS=1 and index>0 and all active nibbles from index up to 3 are zero.
- A digit under leading-zero suppression is dark even if its dp bit is set.

Test Plan:
- Sim params for all scenarios: REFRESH_CYCLES=4, GAP_CYCLES=1.
- Reset release, no load → SSEG_AN cycles 1110,1111,1101,1111,1011,1111,0111,1111. SSEG_CA=1000000 ("0", dp off) during each SHOW. frame_tick on the first 3→0 wrap, 20 clocks after the first SHOW cycle.
- load value=16'h12AF, dp=4'b0100 mid-frame → old data until the next frame_tick. Then digits 0..3 show F, A, 2 (CA=00100100, dp lit), 1.
- load 16'h1111 then 16'h2222 within one frame → next frame shows 2222 only. A load asserted on the frame_tick cycle is visible in that same frame.
- LZ_SUPPRESS=1, value=16'h0005 → digits 3..1 CA=8'hFF, digit 0 CA=0010010. value=16'h0000 → digit 0 shows "0". value=16'h0500 → only digit 3 dark, digit 0 shows "0".
- blank=4'b1000 with value=16'h8888 → digit 3 CA=8'hFF while its anode is still driven low; others CA=0000000.
- Assert reset during digit 2 SHOW → next edge SSEG_AN=4'hF, SSEG_CA=8'hFF. After release, scan restarts at digit 0 showing "0".
- GAP_CYCLES=0 → anodes step directly 1110→1101 with no all-off cycle; digit period = 4 clocks.
